// File: rtl/fsm_inspeccion_param_if.sv
// rtl/fsm_inspeccion_param_if.sv - sensor/actuator bundle for the inspection-line controller
interface fsm_inspeccion_param_if #(
  parameter int CNT_W = 8
);
  logic             P;
  logic             ri_valid;
  logic             RI;
  logic             ack;
  logic             clr_alarm;
  logic [1:0]       E;
  logic [1:0]       Y;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             alarm;

  // Sensor/actuator side: drives product, verdict, ack and alarm clear
  modport master (
    output P, ri_valid, RI, ack, clr_alarm,
    input  E, Y, pass_cnt, fail_cnt, alarm
  );

  // Controller side
  modport slave (
    input  P, ri_valid, RI, ack, clr_alarm,
    output E, Y, pass_cnt, fail_cnt, alarm
  );
endinterface

// File: rtl/fsm_inspeccion_param.sv
// rtl/fsm_inspeccion_param.sv - inspection FSM with retries, ack handshake, counters, alarm; optional watchdog via INSPECT_TIMEOUT_EN
module fsm_inspeccion_param #(
  parameter int CNT_W          = 8,
  parameter int MAX_RETRY      = 2,
  parameter int ALARM_THRESH   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  fsm_inspeccion_param_if.slave bus
);

  // State encoding doubles as the E status code
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_INSPECT = 2'b01,
    S_PASS    = 2'b10,
    S_FAIL    = 2'b11
  } state_t;

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int AW = $clog2(ALARM_THRESH + 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [AW-1:0]    THRESH    = AW'(ALARM_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [AW-1:0]    consec_q, consec_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             alarm_q, alarm_d;

  // clr_alarm takes effect before a same-cycle reject is counted
  logic [AW-1:0] consec_base;
  logic          alarm_base;
  logic [AW-1:0] consec_inc;

`ifdef INSPECT_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wdog_q, wdog_d;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

  // State register and all datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      retry_q    <= '0;
      consec_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      alarm_q    <= 1'b0;
`ifdef INSPECT_TIMEOUT_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      consec_q   <= consec_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      alarm_q    <= alarm_d;
`ifdef INSPECT_TIMEOUT_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

  // Next-state and counter/alarm update rules
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    consec_base = bus.clr_alarm ? '0 : consec_q;
    alarm_base  = bus.clr_alarm ? 1'b0 : alarm_q;
    consec_inc  = (consec_base >= THRESH) ? THRESH : consec_base + 1'b1;
    consec_d    = consec_base;
    alarm_d     = alarm_base;
`ifdef INSPECT_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.P && !alarm_q) begin
          state_d = S_INSPECT;
          retry_d = '0;
`ifdef INSPECT_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      S_INSPECT: begin
        if (!bus.P) begin
          state_d = S_IDLE;
        end else if (bus.ri_valid) begin
`ifdef INSPECT_TIMEOUT_EN
          wdog_d = '0;
`endif
          if (bus.RI) begin
            state_d = S_PASS;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
`ifdef INSPECT_TIMEOUT_EN
          if (wdog_q >= WDOG_LAST) begin
            state_d = S_FAIL;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
`endif
        end
      end
      S_PASS: begin
        if (bus.ack) begin
          state_d    = S_IDLE;
          pass_cnt_d = (pass_cnt_q == CNT_MAX) ? CNT_MAX : pass_cnt_q + 1'b1;
          consec_d   = '0;
        end
      end
      S_FAIL: begin
        if (bus.ack) begin
          state_d    = S_IDLE;
          fail_cnt_d = (fail_cnt_q == CNT_MAX) ? CNT_MAX : fail_cnt_q + 1'b1;
          consec_d   = consec_inc;
          alarm_d    = alarm_base | (consec_inc >= THRESH);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore status from state; Mealy routing command from state, ack, P and alarm
  always_comb begin
    bus.E = state_q;
    bus.Y = 2'b00;
    case (state_q)
      S_IDLE:  if (bus.P && alarm_q) bus.Y = 2'b11;
      S_PASS:  if (!bus.ack) bus.Y = 2'b01;
      S_FAIL:  if (!bus.ack) bus.Y = 2'b10;
      default: bus.Y = 2'b00;
    endcase
    bus.pass_cnt = pass_cnt_q;
    bus.fail_cnt = fail_cnt_q;
    bus.alarm    = alarm_q;
  end

endmodule

// File: tb/tb_fsm_inspeccion_param.sv
// tb/tb_fsm_inspeccion_param.sv - directed and randomized checks of fsm_inspeccion_param against a reference model
module tb_fsm_inspeccion_param;
  localparam int CNT_W = 2;
  localparam int MAX_RETRY = 2;
  localparam int ALARM_THRESH = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passed = 0;

  int m_state, m_retry, m_consec, m_pass, m_fail, m_alarm, m_wd;

  fsm_inspeccion_param_if #(.CNT_W(CNT_W)) bus_if ();

  fsm_inspeccion_param #(
    .CNT_W(CNT_W), .MAX_RETRY(MAX_RETRY),
    .ALARM_THRESH(ALARM_THRESH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_retry = 0; m_consec = 0; m_pass = 0; m_fail = 0; m_alarm = 0; m_wd = 0;
  endtask

  function automatic int model_y();
    case (m_state)
      0: return (bus_if.P && m_alarm != 0) ? 3 : 0;
      2: return bus_if.ack ? 0 : 1;
      3: return bus_if.ack ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_clock();
    int ns;
    int alarm_before;
    ns = m_state;
    alarm_before = m_alarm;
    if (bus_if.clr_alarm) begin m_alarm = 0; m_consec = 0; end
    case (m_state)
      0: if (bus_if.P && alarm_before == 0) begin ns = 1; m_retry = 0; m_wd = 0; end
      1: begin
        if (!bus_if.P) ns = 0;
        else if (bus_if.ri_valid) begin
          m_wd = 0;
          if (bus_if.RI) ns = 2;
          else if (m_retry < MAX_RETRY) m_retry++;
          else ns = 3;
        end else begin
`ifdef INSPECT_TIMEOUT_EN
          m_wd++;
          if (m_wd >= TIMEOUT_CYCLES) ns = 3;
`endif
        end
      end
      2: if (bus_if.ack) begin ns = 0; m_pass = (m_pass < CNT_SAT) ? m_pass + 1 : CNT_SAT; m_consec = 0; end
      default: if (bus_if.ack) begin
        ns = 0;
        m_fail = (m_fail < CNT_SAT) ? m_fail + 1 : CNT_SAT;
        m_consec = (m_consec < ALARM_THRESH) ? m_consec + 1 : ALARM_THRESH;
        if (m_consec >= ALARM_THRESH) m_alarm = 1;
      end
    endcase
    m_state = ns;
  endtask

  task automatic set_in(input logic p, input logic rv, input logic ri, input logic a, input logic c);
    bus_if.P = p; bus_if.ri_valid = rv; bus_if.RI = ri; bus_if.ack = a; bus_if.clr_alarm = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_pass();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 1, 1, 0, 0); tick();
    set_in(0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic do_reject();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 0, 0);
    for (int i = 0; i <= MAX_RETRY; i++) tick();
    set_in(0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    #3;
    checks++; if (bus_if.E !== 2'b00) $display("FAIL reset_E got=%0d exp=0", bus_if.E); else passed++;
    checks++; if (bus_if.Y !== 2'b00) $display("FAIL reset_Y got=%0d exp=0", bus_if.Y); else passed++;
    checks++; if (bus_if.pass_cnt !== 0 || bus_if.fail_cnt !== 0) $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus_if.pass_cnt, bus_if.fail_cnt); else passed++;
    checks++; if (bus_if.alarm !== 1'b0) $display("FAIL reset_alarm got=%0b exp=0", bus_if.alarm); else passed++;
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_pass_flow();
    do_reset();
    set_in(1, 0, 0, 0, 0); tick();
    checks++; if (bus_if.E !== 2'b01) $display("FAIL pass_E_inspect got=%0d exp=1", bus_if.E); else passed++;
    set_in(1, 1, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0); #1;
    checks++; if (bus_if.E !== 2'b10 || bus_if.Y !== 2'b01) $display("FAIL pass_E_Y got=%0d/%0d exp=2/1", bus_if.E, bus_if.Y); else passed++;
    tick();
    checks++; if (bus_if.Y !== 2'b01) $display("FAIL pass_Y_hold got=%0d exp=1", bus_if.Y); else passed++;
    set_in(0, 0, 0, 1, 0); #1;
    checks++; if (bus_if.Y !== 2'b00) $display("FAIL pass_Y_ack_drop got=%0d exp=0", bus_if.Y); else passed++;
    tick();
    set_in(0, 0, 0, 0, 0);
    checks++; if (bus_if.E !== 2'b00 || bus_if.pass_cnt !== 1) $display("FAIL pass_done E/cnt got=%0d/%0d exp=0/1", bus_if.E, bus_if.pass_cnt); else passed++;
  endtask

  task automatic test_retry_fail();
    do_reset();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 0, 0);
    for (int i = 0; i < MAX_RETRY; i++) begin
      tick();
      checks++; if (bus_if.E !== 2'b01) $display("FAIL retry_E_%0d got=%0d exp=1", i, bus_if.E); else passed++;
    end
    tick();
    set_in(1, 0, 0, 0, 0); #1;
    checks++; if (bus_if.E !== 2'b11 || bus_if.Y !== 2'b10) $display("FAIL retry_fail_E_Y got=%0d/%0d exp=3/2", bus_if.E, bus_if.Y); else passed++;
    set_in(1, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0);
    checks++; if (bus_if.E !== 2'b00 || bus_if.fail_cnt !== 1 || bus_if.pass_cnt !== 0) $display("FAIL retry_fail_cnt E/fail/pass got=%0d/%0d/%0d exp=0/1/0", bus_if.E, bus_if.fail_cnt, bus_if.pass_cnt); else passed++;
  endtask

  task automatic test_alarm();
    do_reset();
    for (int i = 0; i < ALARM_THRESH; i++) begin
      checks++; if (bus_if.alarm !== 1'b0) $display("FAIL alarm_early_%0d got=1 exp=0", i); else passed++;
      do_reject();
    end
    checks++; if (bus_if.alarm !== 1'b1) $display("FAIL alarm_set got=%0b exp=1", bus_if.alarm); else passed++;
    set_in(1, 0, 0, 0, 0); #1;
    checks++; if (bus_if.Y !== 2'b11) $display("FAIL alarm_Y_stop got=%0d exp=3", bus_if.Y); else passed++;
    tick();
    checks++; if (bus_if.E !== 2'b00) $display("FAIL alarm_hold_idle got=%0d exp=0", bus_if.E); else passed++;
    set_in(1, 0, 0, 0, 1); tick();
    set_in(1, 0, 0, 0, 0); #1;
    checks++; if (bus_if.alarm !== 1'b0 || bus_if.E !== 2'b00) $display("FAIL alarm_clr alarm/E got=%0b/%0d exp=0/0", bus_if.alarm, bus_if.E); else passed++;
    tick();
    checks++; if (bus_if.E !== 2'b01) $display("FAIL alarm_resume got=%0d exp=1", bus_if.E); else passed++;
    set_in(0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_saturation_abort();
    do_reset();
    for (int i = 0; i < 5; i++) do_pass();
    checks++; if (bus_if.pass_cnt !== CNT_W'(CNT_SAT)) $display("FAIL pass_saturate got=%0d exp=%0d", bus_if.pass_cnt, CNT_SAT); else passed++;
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 1, 0, 0); tick();
    checks++; if (bus_if.E !== 2'b00) $display("FAIL abort_E got=%0d exp=0", bus_if.E); else passed++;
    checks++; if (bus_if.pass_cnt !== CNT_W'(CNT_SAT) || bus_if.fail_cnt !== 0) $display("FAIL abort_cnt pass/fail got=%0d/%0d exp=%0d/0", bus_if.pass_cnt, bus_if.fail_cnt, CNT_SAT); else passed++;
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_fail_and_clr();
    do_reset();
    do_pass(); do_reject();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 0, 0);
    for (int i = 0; i <= MAX_RETRY; i++) tick();
    set_in(1, 0, 0, 1, 0); #1;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (bus_if.E !== 2'b00 || bus_if.Y !== 2'b00) $display("FAIL midreset_E_Y got=%0d/%0d exp=0/0", bus_if.E, bus_if.Y); else passed++;
    checks++; if (bus_if.pass_cnt !== 0 || bus_if.fail_cnt !== 0 || bus_if.alarm !== 1'b0) $display("FAIL midreset_cnt pass/fail/alarm got=%0d/%0d/%0b exp=0/0/0", bus_if.pass_cnt, bus_if.fail_cnt, bus_if.alarm); else passed++;
    #2;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);
    do_reject(); do_reject();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 0, 0);
    for (int i = 0; i <= MAX_RETRY; i++) tick();
    set_in(0, 0, 0, 1, 1); tick();
    set_in(0, 0, 0, 0, 0);
    checks++; if (bus_if.alarm !== 1'b0) $display("FAIL clr_with_ack_alarm got=%0b exp=0", bus_if.alarm); else passed++;
    do_reject();
    checks++; if (bus_if.alarm !== 1'b0) $display("FAIL clr_consec_two got=%0b exp=0", bus_if.alarm); else passed++;
    do_reject();
    checks++; if (bus_if.alarm !== 1'b1) $display("FAIL clr_consec_three got=%0b exp=1", bus_if.alarm); else passed++;
    set_in(0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    logic [1:0] exp_e;
`ifdef INSPECT_TIMEOUT_EN
    exp_e = 2'b11;
`else
    exp_e = 2'b01;
`endif
    do_reset();
    set_in(1, 0, 0, 0, 0); tick();
    for (int i = 1; i < TIMEOUT_CYCLES; i++) tick();
    checks++; if (bus_if.E !== 2'b01) $display("FAIL timeout_before got=%0d exp=1", bus_if.E); else passed++;
    tick();
    checks++; if (bus_if.E !== exp_e) $display("FAIL timeout_at_limit got=%0d exp=%0d", bus_if.E, exp_e); else passed++;
    set_in(0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    checks++; if (bus_if.E !== 2'b00) $display("FAIL timeout_exit got=%0d exp=0", bus_if.E); else passed++;
  endtask

  task automatic test_random();
    int ey;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 55,
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 5);
      #1;
      ey = model_y();
      checks++;
      if (bus_if.E !== m_state[1:0] || bus_if.Y !== ey[1:0] || bus_if.pass_cnt !== m_pass[CNT_W-1:0] ||
          bus_if.fail_cnt !== m_fail[CNT_W-1:0] || bus_if.alarm !== m_alarm[0])
        $display("FAIL random_%0d E/Y/pass/fail/alarm got=%0d/%0d/%0d/%0d/%0b exp=%0d/%0d/%0d/%0d/%0d",
                 n, bus_if.E, bus_if.Y, bus_if.pass_cnt, bus_if.fail_cnt, bus_if.alarm,
                 m_state, ey, m_pass, m_fail, m_alarm);
      else passed++;
      tick();
    end
    set_in(0, 0, 0, 0, 0);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_pass_flow();
    test_retry_fail();
    test_alarm();
    test_saturation_abort();
    test_reset_mid_fail_and_clr();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fsm_inspeccion_param.md
# fsm_inspeccion_param

Parametrised inspection-line controller that merges the Moore inspection FSM and the Mealy routing protocol into one block. It adds retries on a failed inspection, an acknowledge handshake toward the actuator, saturating pass/fail counters, and a consecutive-reject alarm that stops the line. It sits between the product/inspection sensor inputs and the routing actuator outputs in the top level.

## Interface
- CNT_W, 8: width of the pass/fail counters.
- MAX_RETRY, 2: re-inspections allowed after a negative verdict before the product is rejected (0 = no retry).
- ALARM_THRESH, 3: consecutive rejects that raise `alarm` (≥1).
- TIMEOUT_CYCLES, 16: verdict watchdog length; used only with `INSPECT_TIMEOUT_EN`.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- P  in  1  product present at the station.
- ri_valid  in  1  inspection verdict valid this cycle.
- RI  in  1  verdict: 1 = good, 0 = bad; sampled only when `ri_valid=1`.
- ack  in  1  actuator has executed the current routing command.
- clr_alarm  in  1  clears the alarm and the consecutive-reject count.
- E  out  2  Moore station status: 00 idle, 01 inspecting, 10 pass, 11 fail.
- Y  out  2  Mealy routing command: 00 none, 01 route good, 10 route reject, 11 line stop.
- pass_cnt  out  CNT_W  accepted products, saturating.
- fail_cnt  out  CNT_W  rejected products, saturating.
- alarm  out  1  line-stop alarm.

## Operation
- States: IDLE (E=00), INSPECT (E=01), PASS (E=10), FAIL (E=11). E decodes from the state register only.
- IDLE:
  - `P=1` and `alarm=0` → INSPECT; retry count cleared.
  - `P=1` and `alarm=1` → stay in IDLE; Y=11 combinationally.
- INSPECT:
  - `P=0` → IDLE (abort); no counter changes.
  - Otherwise, `ri_valid & RI` → PASS.
  - `ri_valid & ~RI` with retry < MAX_RETRY → stay in INSPECT; retry +1.
  - `ri_valid & ~RI` with retry = MAX_RETRY → FAIL.
- PASS:
  - Y=01 while `ack=0`.
  - `ack=1` → IDLE; pass_cnt +1; consecutive-reject count cleared.
  - `alarm` is unaffected by a pass.
- FAIL:
  - Y=10 while `ack=0`.
  - `ack=1` → IDLE; fail_cnt +1; consecutive count +1.
  - `alarm` sets when the new consecutive count ≥ ALARM_THRESH.
- In PASS and FAIL, Y drops to 00 in the same cycle that `ack=1`, because Y is Mealy.
- Y is 00 in every case not listed above. P is ignored in PASS and FAIL.
- Counters saturate at 2^CNT_W−1 and never wrap. The consecutive count saturates at ALARM_THRESH.
- `clr_alarm` and a FAIL ack in the same cycle: clear first, then count. The consecutive count becomes 1, and `alarm` is set only if ALARM_THRESH=1.
- `clr_alarm` in any state clears `alarm` and the consecutive count. It has no effect on state or the other counters.

## Timing
- Reset (asynchronous, any state, including mid-handshake):
  - state IDLE, E=00, all counters 0, retry 0, `alarm`=0.
  - Y=00 unless `P=1`. With `alarm`=0, Y=00 regardless of P.
- State, counters and `alarm` update on the clock edge that sees the qualifying input.
- Latency P→E=01 is one cycle. Verdict→E=10/11 is one cycle. ack→E=00 is one cycle, with counters updating on that same edge.
- Y depends combinationally on the current state, `ack`, `P` and `alarm`; it has no register stage.
- Minimum product cycle is 3 clocks: IDLE→INSPECT, INSPECT→PASS/FAIL, ack→IDLE.

## Configuration
- `INSPECT_TIMEOUT_EN` defined:
  - A watchdog counts consecutive INSPECT cycles without `ri_valid`.
  - On reaching TIMEOUT_CYCLES → FAIL, exactly as an exhausted retry.
  - The watchdog reloads on every `ri_valid` and on entry to INSPECT.
- Undefined: INSPECT waits indefinitely for a verdict; TIMEOUT_CYCLES is ignored and no watchdog logic is built.

## Test plan
- Reset, then P=1, then ri_valid=1 with RI=1 one cycle later, then ack=1 → E 00→01→10→00; Y=01 until ack; pass_cnt=1.
- MAX_RETRY=2, three bad verdicts → E stays 01 through two retries; third bad verdict → E=11, Y=10; ack → fail_cnt=1.
- ALARM_THRESH=3, three rejects acked → alarm=1; next P=1 → E=00, Y=11; clr_alarm → next P enters INSPECT.
- CNT_W=2, five passes → pass_cnt saturates at 3; P dropped mid-INSPECT → E=00, counters unchanged.
- Reset asserted in FAIL with ack pending → immediate E=00, Y=00, all counters 0; clr_alarm coincident with a FAIL ack → consecutive count = 1.
- With `INSPECT_TIMEOUT_EN`, TIMEOUT_CYCLES=16 and no ri_valid → E=11 after 16 cycles in INSPECT; without the macro → E stays 01.
